// File: rtl/uart_rx_fifo.sv
// UART receiver with a two-flop synchroniser, three-sample majority voting,
// parity/framing checks and a first-word fall-through output FIFO.
module uart_rx_fifo #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int N_BITS     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  input  logic              rx_ready,
  input  logic              clear_overflow,
  output logic              rx_valid,
  output logic [N_BITS-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int P  = CLOCK_HZ / BAUD_RATE;
  localparam int H  = P / 2;
  localparam int CW = $clog2(P);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = N_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW-1:0] CNT_V0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(H);
  localparam logic [CW-1:0] CNT_V2   = CW'(H + 1);
  localparam logic [3:0]    DATA_LAST = 4'(N_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic              sync1, rx_s;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_idx;
  logic              smp0, smp1;
  logic [N_BITS-1:0] shreg;
  logic              par_err, frm_err;
  logic              vote, at_vote, cnt_wrap, push;
  logic [W-1:0]      push_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  assign vote      = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign at_vote   = (cnt == CNT_V2);
  assign cnt_wrap  = (cnt == CNT_LAST);
  assign push_word = {frm_err | ~vote, par_err, shreg};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      S_IDLE:   if (!rx_s) state_n = S_START;
      S_START: begin
        if (at_vote && vote) state_n = S_IDLE;
        else if (cnt_wrap)   state_n = S_DATA;
      end
      S_DATA:
        if (cnt_wrap && bit_idx == DATA_LAST)
          state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (cnt_wrap) state_n = S_STOP;
      S_STOP: begin
        // The last stop bit ends at its vote so a closely following start edge is caught.
        if (at_vote && bit_idx == STOP_LAST) begin
          push    = 1'b1;
          state_n = S_IDLE;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      smp0    <= 1'b1;
      smp1    <= 1'b1;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (state == S_IDLE || state_n == S_IDLE || cnt_wrap) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);

      if (state == S_IDLE) begin
        bit_idx <= '0;
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end else if (cnt_wrap) begin
        bit_idx <= (state_n != state) ? 4'd0 : bit_idx + 4'd1;
      end

      if (cnt == CNT_V0) smp0 <= rx_s;
      if (cnt == CNT_V1) smp1 <= rx_s;

      if (at_vote) begin
        case (state)
          S_DATA:   shreg   <= {vote, shreg[N_BITS-1:1]};
          S_PARITY: par_err <= (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
          S_STOP:   frm_err <= frm_err | ~vote;
          default:  ;
        endcase
      end
    end
  end

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         empty, full, pop, do_push;
  logic [W-1:0] head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && rx_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
    end
  end

  // Outputs are forced to zero while empty so stale storage never shows.
  assign head          = mem[rd_ptr[AW-1:0]];
  assign rx_valid      = !empty;
  assign rx_data       = rx_valid ? head[N_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[N_BITS];
  assign rx_frame_err  = rx_valid & head[N_BITS+1];
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances cover 8N1, even parity and
// two stop bits at P = 50 clocks per bit.
module tb_uart_rx_fifo;

  localparam int P = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rxd_a = 1'b1, ready_a = 1'b0, clr_a = 1'b0;
  logic       valid_a, perr_a, ferr_a, ovf_a, busy_a;
  logic [7:0] data_a;
  logic       rxd_b = 1'b1, ready_b = 1'b0, clr_b = 1'b0;
  logic       valid_b, perr_b, ferr_b, ovf_b, busy_b;
  logic [7:0] data_b;
  logic       rxd_c = 1'b1, ready_c = 1'b0, clr_c = 1'b0;
  logic       valid_c, perr_c, ferr_c, ovf_c, busy_c;
  logic [7:0] data_c;

  uart_rx_fifo #(.BAUD_RATE(1_000_000), .CLOCK_HZ(50_000_000), .N_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .rxd(rxd_a), .rx_ready(ready_a),
    .clear_overflow(clr_a), .rx_valid(valid_a), .rx_data(data_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .overflow(ovf_a), .busy(busy_a));

  uart_rx_fifo #(.BAUD_RATE(1_000_000), .CLOCK_HZ(50_000_000), .N_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .rxd(rxd_b), .rx_ready(ready_b),
    .clear_overflow(clr_b), .rx_valid(valid_b), .rx_data(data_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .overflow(ovf_b), .busy(busy_b));

  uart_rx_fifo #(.BAUD_RATE(1_000_000), .CLOCK_HZ(50_000_000), .N_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .rxd(rxd_c), .rx_ready(ready_c),
    .clear_overflow(clr_c), .rx_valid(valid_c), .rx_data(data_c),
    .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .overflow(ovf_c), .busy(busy_c));

  // Drives n line bits LSB first, each held for P clocks; called on a negedge.
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       rxd_a = bits[i];
        1:       rxd_b = bits[i];
        default: rxd_c = bits[i];
      endcase
      repeat (P) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_a); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", data_a); end
    checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {perr_a, ferr_a}); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf_a); end
    checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin errors++; $display("FAIL rst_busy: got %b want 000", {busy_a, busy_b, busy_c}); end
    checks++; if ({valid_b, valid_c} !== 2'b00) begin errors++; $display("FAIL rst_valid_bc: got %b want 00", {valid_b, valid_c}); end
  endtask

  task automatic test_8n1;
    int  c_edge, c_busy, c_valid;
    bit  got_b, got_v, busy_at_v;
    @(negedge clk);
    c_edge = cyc; c_busy = 0; c_valid = 0;
    got_b = 1'b0; got_v = 1'b0; busy_at_v = 1'b1;
    fork
      send_bits(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
      begin
        for (int k = 0; k < 700 && !got_v; k++) begin
          @(negedge clk);
          if (!got_b && busy_a) begin got_b = 1'b1; c_busy = cyc; end
          if (valid_a) begin got_v = 1'b1; c_valid = cyc; busy_at_v = busy_a; end
        end
      end
    join
    checks++; if (!got_b || (c_busy - c_edge) < 3 || (c_busy - c_edge) > 4) begin errors++; $display("FAIL t1_busy_lat: got %0d want 3..4", c_busy - c_edge); end
    checks++; if (!got_v || (c_valid - c_busy) != 477) begin errors++; $display("FAIL t1_valid_lat: got %0d want 477", c_valid - c_busy); end
    checks++; if (busy_at_v !== 1'b0) begin errors++; $display("FAIL t1_busy_fall: got %b want 0", busy_at_v); end
    checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL t1_data: got %h want a5", data_a); end
    checks++; if ({perr_a, ferr_a} !== 2'b00) begin errors++; $display("FAIL t1_err: got %b want 00", {perr_a, ferr_a}); end
    ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t1_pop: got %b want 0", valid_a); end
  endtask

  task automatic test_parity;
    send_bits(1, {5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL t2_valid1: got %b want 1", valid_b); end
    checks++; if (data_b !== 8'h03) begin errors++; $display("FAIL t2_data1: got %h want 03", data_b); end
    checks++; if ({ferr_b, perr_b} !== 2'b01) begin errors++; $display("FAIL t2_err1: got %b want 01", {ferr_b, perr_b}); end
    ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
    send_bits(1, {5'h1f, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    checks++; if (data_b !== 8'h03) begin errors++; $display("FAIL t2_data2: got %h want 03", data_b); end
    checks++; if ({valid_b, ferr_b, perr_b} !== 3'b100) begin errors++; $display("FAIL t2_err2: got %b want 100", {valid_b, ferr_b, perr_b}); end
    ready_b = 1'b1; @(negedge clk); ready_b = 1'b0;
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL t2_pop: got %b want 0", valid_b); end
  endtask

  task automatic test_stop2;
    send_bits(2, {5'h1f, 1'b0, 1'b1, 8'h5A, 1'b0}, 11);
    rxd_c = 1'b1;
    checks++; if (data_c !== 8'h5A) begin errors++; $display("FAIL t3_data: got %h want 5a", data_c); end
    checks++; if ({valid_c, ferr_c, perr_c} !== 3'b110) begin errors++; $display("FAIL t3_err: got %b want 110", {valid_c, ferr_c, perr_c}); end
    repeat (2 * P) @(negedge clk);
    ready_c = 1'b1; @(negedge clk); ready_c = 1'b0;
    checks++; if ({valid_c, busy_c} !== 2'b00) begin errors++; $display("FAIL t3_tail: got %b want 00", {valid_c, busy_c}); end
  endtask

  task automatic test_glitch;
    int  c_edge, c_fall;
    bit  fell;
    @(negedge clk);
    c_edge = cyc; c_fall = 0; fell = 1'b0;
    rxd_a = 1'b0;
    repeat (10) @(negedge clk);
    rxd_a = 1'b1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL t4_busy_rise: got %b want 1", busy_a); end
    for (int k = 0; k < 2 * P && !fell; k++) begin
      @(negedge clk);
      if (!busy_a) begin fell = 1'b1; c_fall = cyc; end
    end
    checks++; if (!fell || (c_fall - c_edge) < 30 || (c_fall - c_edge) > 31) begin errors++; $display("FAIL t4_busy_fall: got %0d want 30..31", c_fall - c_edge); end
    repeat (P) @(negedge clk);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t4_nopush: got %b want 0", valid_a); end
    send_bits(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10);
    checks++; if ({valid_a, data_a, perr_a, ferr_a} !== {1'b1, 8'h3C, 2'b00}) begin errors++; $display("FAIL t4_data: got %b/%h/%b want 1/3c/00", valid_a, data_a, {perr_a, ferr_a}); end
    ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) send_bits(0, {6'h3f, 1'b1, 8'(i), 1'b0}, 10);
    checks++; if ({valid_a, ovf_a} !== 2'b11) begin errors++; $display("FAIL t5_ovf: got %b want 11", {valid_a, ovf_a}); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (data_a !== 8'(i)) begin errors++; $display("FAIL t5_order%0d: got %h want %h", i, data_a, 8'(i)); end
      ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
    end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t5_drain: got %b want 0", valid_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL t5_sticky: got %b want 1", ovf_a); end
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL t5_clear: got %b want 0", ovf_a); end
  endtask

  task automatic test_mid_reset;
    send_bits(0, {6'h3f, 1'b1, 8'h81, 1'b0}, 10);
    checks++; if ({valid_a, data_a} !== {1'b1, 8'h81}) begin errors++; $display("FAIL t6_pre: got %b/%h want 1/81", valid_a, data_a); end
    send_bits(0, 16'h0000, 5);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL t6_busy: got %b want 1", busy_a); end
    reset = 1'b1; rxd_a = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({valid_a, data_a, perr_a, ferr_a, ovf_a, busy_a} !== 13'h0) begin errors++; $display("FAIL t6_outs: got %h want 0", {valid_a, data_a, perr_a, ferr_a, ovf_a, busy_a}); end
    repeat (6 * P) @(negedge clk);
    checks++; if ({valid_a, busy_a} !== 2'b00) begin errors++; $display("FAIL t6_nopush: got %b want 00", {valid_a, busy_a}); end
    send_bits(0, {6'h3f, 1'b1, 8'hFF, 1'b0}, 10);
    checks++; if ({valid_a, data_a, perr_a, ferr_a} !== {1'b1, 8'hFF, 2'b00}) begin errors++; $display("FAIL t6_data: got %b/%h/%b want 1/ff/00", valid_a, data_a, {perr_a, ferr_a}); end
    ready_a = 1'b1; @(negedge clk); ready_a = 1'b0;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL t6_pop: got %b want 0", valid_a); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_stop2();
    test_glitch();
    test_overflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
